usb_serial_pkt_ep: RTL and testbench
====================================

# usb_serial_pkt_ep

Parametrised successor to the single-FIFO USB serial endpoint. Bridges a byte-stream UART-style interface to the USB bulk IN/OUT endpoint interfaces. Buffers both directions. Applies real backpressure on OUT by withholding the request. Packetises IN data with a size threshold, an idle-flush timer and optional zero-length-packet (ZLP) termination.

## Interface
- `TX_DEPTH`, default 64: IN-direction FIFO depth in bytes; power of two, ≥ 2×`MAX_PKT`.
- `RX_DEPTH`, default 64: OUT-direction FIFO depth in bytes; power of two, ≥ `MAX_PKT`.
- `MAX_PKT`, default 32: maximum IN/OUT packet payload in bytes; range 8..64.
- `FLUSH_CYCLES`, default 4096: idle clocks before a partial IN packet is sent; ≥ 1.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `out_ep_req` out 1: request the OUT buffer.
- `out_ep_grant` in 1: OUT buffer granted.
- `out_ep_data_avail` in 1: host data pending.
- `out_ep_setup` in 1: setup packet flag; ignored.
- `out_ep_data_get` out 1: read strobe.
- `out_ep_data` in 8: OUT byte, valid one cycle after `out_ep_data_get`.
- `out_ep_stall` out 1: constant 0.
- `out_ep_acked` in 1: unused.
- `in_ep_req` out 1: request the IN buffer.
- `in_ep_grant` in 1: IN buffer granted.
- `in_ep_data_free` in 1: IN buffer can take a byte.
- `in_ep_data_put` out 1: write strobe.
- `in_ep_data` out 8: IN byte.
- `in_ep_data_done` out 1: packet complete.
- `in_ep_stall` out 1: constant 0.
- `in_ep_acked` in 1: host acknowledged the last IN packet.
- `uart_tx_ready` out 1: TX FIFO not full.
- `uart_tx_data` in 8: byte to the host.
- `uart_tx_strobe` in 1: push; ignored when `uart_tx_ready`=0.
- `uart_rx_data` out 8: byte from the host.
- `uart_rx_valid` out 1: RX FIFO not empty.
- `uart_rx_ready` in 1: pop when valid.
- `tx_level` out $clog2(TX_DEPTH)+1: TX FIFO occupancy.
- `rx_level` out $clog2(RX_DEPTH)+1: RX FIFO occupancy.

## Operation
- OUT path:
  - `out_ep_req` = `out_ep_data_avail` && RX free space ≥ `MAX_PKT`. A whole packet always fits, so there is no mid-packet stall.
  - `out_ep_data_get` = `out_ep_grant`.
  - A registered copy of (grant && avail) writes `out_ep_data` into the RX FIFO on the following cycle.
- IN state machine:
  - `IDLE`:
    - If `tx_level` ≥ `MAX_PKT`, or (`tx_level` > 0 and the flush timer has expired), go to `FILL` with `cnt` = `MAX_PKT`.
    - The flush timer counts while `tx_level` > 0 and the state is `IDLE`. It clears on any TX push and on leaving `IDLE`.
  - `FILL`:
    - `in_ep_req`=1.
    - Pop when `in_ep_grant` && `in_ep_data_free` && FIFO not empty && `cnt` ≠ 0. Decrement `cnt` on each pop.
    - Last byte: `cnt`==1, or the FIFO holds exactly one byte with no simultaneous push. `in_ep_data_done` is raised with that byte's put.
    - After the last byte, go to `WAIT`. A full packet that emptied the FIFO goes to `ZLP` instead, only when ZLP is enabled (see Configuration).
  - `ZLP`: once granted and free, pulse `in_ep_data_done` without `in_ep_data_put`, then go to `WAIT`.
  - `WAIT`: hold until `in_ep_acked`, then go to `IDLE`. `in_ep_req` is 0.
- Simultaneous push and pop on either FIFO is legal; the level is unchanged.
- A push to a full FIFO is dropped.

## Timing
- All outputs are registered except `out_ep_req`, `out_ep_data_get`, `uart_tx_ready` and `uart_rx_valid`.
- Reset values:
  - State `IDLE`, all strobes 0, `in_ep_req` 0, `in_ep_data` 0.
  - Levels 0, FIFO pointers 0, timer 0.
  - `uart_rx_data` 0.
- IN latency: a pop in cycle N gives `in_ep_data_put` and `in_ep_data` in cycle N+1.
- OUT latency:
  - RX write 2 cycles after `out_ep_data_get`.
  - `uart_rx_valid` rises in the cycle after that write.
- Flush: a single byte pushed into an idle, empty block causes `in_ep_req` `FLUSH_CYCLES`+1 cycles after the push.
- Pointers wrap modulo depth. Level uses one extra bit to distinguish full from empty.
- Reset asserted mid-packet: all FIFO contents are discarded and no `in_ep_data_done` is issued.

## Configuration
- Macro `USB_SERIAL_ZLP_EN`.
- Defined: the `ZLP` state exists. A `MAX_PKT`-byte packet that leaves the TX FIFO empty is followed by a zero-length packet.
- Undefined: `FILL` goes straight to `WAIT`, and a full packet never triggers a ZLP.

## Structure
- Package `usb_serial_pkg` holds:
  - the IN state enum (`IDLE`, `FILL`, `ZLP`, `WAIT`);
  - width helper functions for level and counter sizing.
- Sub-module `usb_serial_fifo`, instantiated twice:
  - synchronous, first-word-fall-through;
  - parameters `DEPTH` and `WIDTH`;
  - outputs for `level`, `empty` and `full`.

## Test plan
- 32 pushes (0x00..0x1F) with `MAX_PKT`=32 → exactly 32 puts in order, `in_ep_data_done` on the byte 0x1F. With ZLP enabled, one done without a put follows after `in_ep_acked`.
- 5 pushes with `FLUSH_CYCLES`=16 → `in_ep_req` 17 cycles after the last push, 5 puts, done on the fifth; no ZLP.
- RX FIFO at 40/64 with `uart_rx_ready`=0, `MAX_PKT`=32 → `out_ep_req` held 0 while `out_ep_data_avail`=1. Pop 8 bytes → `out_ep_req` rises.
- 32-byte OUT packet 0xA0..0xBF → `uart_rx_data` presents the same sequence; `rx_level` peaks at 32.
- 64 pushes with grant always asserted → `uart_tx_ready`=0 at level 64; the 65th push is dropped; two packets of 32 are sent.
- `reset` asserted after 10 of 32 puts → all outputs are 0 immediately; levels read 0 after release.

Source files
------------

// File: rtl/usb_serial_pkg.sv
// ============================================================================
// Module      : usb_serial_pkg
// Description : Shared types and sizing helpers for the packetised USB
//               serial endpoint (IN state encoding, level/counter widths).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_serial_pkg;

    // IN-direction packetiser states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_ZLP  = 2'd2,
        ST_WAIT = 2'd3
    } in_state_t;

    // Occupancy width: one extra bit so full and empty are distinct
    function automatic int fn_level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Width of a counter that must hold the value max_val itself
    function automatic int fn_count_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/usb_serial_fifo.sv
// ============================================================================
// Module      : usb_serial_fifo
// Description : Synchronous first-word-fall-through FIFO. Provides the head
//               word combinationally and as a registered copy that tracks
//               the head exactly (bypassing a write into the next head slot).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_serial_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [WIDTH-1:0]         rdata_q,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full_level = DEPTH[c_aw:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw-1:0]  w_rd_ptr_nxt;
    logic [c_aw:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign empty        = (r_level == '0);
    assign full         = (r_level == c_full_level);
    assign level        = r_level;
    assign w_push       = push && !full;
    assign w_pop        = pop && !empty;
    assign rdata        = r_mem[r_rd_ptr];
    assign w_rd_ptr_nxt = r_rd_ptr + c_aw'(w_pop);

    // Storage array; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // Registered head: next cycle's head word, taken from the write port when
    // this cycle's write lands in the slot that becomes the head
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            rdata_q <= wdata;
        end else begin
            rdata_q <= r_mem[w_rd_ptr_nxt];
        end
    end

endmodule

`default_nettype wire

// File: rtl/usb_serial_pkt_ep.sv
// ============================================================================
// Module      : usb_serial_pkt_ep
// Description : Byte-stream (UART-style) to USB bulk IN/OUT endpoint bridge.
//               OUT: request withheld until a whole packet fits in the RX
//               FIFO. IN: packetised by size threshold, idle-flush timer and
//               optional zero-length-packet termination.
//               Build option: define USB_SERIAL_ZLP_EN to send a ZLP after a
//               full-size packet that drains the TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_serial_pkt_ep
    import usb_serial_pkg::*;
#(
    parameter int TX_DEPTH     = 64,
    parameter int RX_DEPTH     = 64,
    parameter int MAX_PKT      = 32,
    parameter int FLUSH_CYCLES = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    // OUT endpoint (host -> device)
    output logic                        out_ep_req,
    input  logic                        out_ep_grant,
    input  logic                        out_ep_data_avail,
    input  logic                        out_ep_setup,
    output logic                        out_ep_data_get,
    input  logic [7:0]                  out_ep_data,
    output logic                        out_ep_stall,
    input  logic                        out_ep_acked,
    // IN endpoint (device -> host)
    output logic                        in_ep_req,
    input  logic                        in_ep_grant,
    input  logic                        in_ep_data_free,
    output logic                        in_ep_data_put,
    output logic [7:0]                  in_ep_data,
    output logic                        in_ep_data_done,
    output logic                        in_ep_stall,
    input  logic                        in_ep_acked,
    // Byte-stream side
    output logic                        uart_tx_ready,
    input  logic [7:0]                  uart_tx_data,
    input  logic                        uart_tx_strobe,
    output logic [7:0]                  uart_rx_data,
    output logic                        uart_rx_valid,
    input  logic                        uart_rx_ready,
    // Status
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [$clog2(RX_DEPTH):0]   rx_level
);

    localparam int c_tx_lw  = fn_level_width(TX_DEPTH);
    localparam int c_rx_lw  = fn_level_width(RX_DEPTH);
    localparam int c_cnt_w  = fn_count_width(MAX_PKT);
    localparam int c_tmr_w  = fn_count_width(FLUSH_CYCLES);

    localparam logic [c_rx_lw-1:0] c_rx_req_max = c_rx_lw'(RX_DEPTH - MAX_PKT);
    localparam logic [c_tx_lw-1:0] c_tx_pkt     = c_tx_lw'(MAX_PKT);
    localparam logic [c_tx_lw-1:0] c_tx_one     = c_tx_lw'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_full   = c_cnt_w'(MAX_PKT);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_tmr_w-1:0] c_tmr_last   = c_tmr_w'(FLUSH_CYCLES - 1);

    // TX (IN-direction) FIFO
    logic       w_tx_push;
    logic       w_tx_pop;
    logic       w_tx_empty;
    logic       w_tx_full;
    logic [7:0] w_tx_head;
    logic [7:0] w_unused_tx_head_q;

    // RX (OUT-direction) FIFO
    logic       w_rx_pop;
    logic       w_rx_empty;
    logic       w_unused_rx_full;
    logic [7:0] w_unused_rx_head;

    // OUT capture pipeline
    logic       r_out_get_d;
    logic       r_out_wr;
    logic [7:0] r_out_data;

    // IN packetiser
    in_state_t          r_state;
    in_state_t          w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_tmr_w-1:0] r_timer;
    logic               w_flush_due;
    logic               w_last;
    logic               w_put_nxt;
    logic               w_done_nxt;
    logic               r_in_req;
    logic               r_in_put;
    logic               r_in_done;
    logic [7:0]         r_in_data;

    // Inputs the endpoint deliberately ignores
    logic w_unused_inputs;
    assign w_unused_inputs = out_ep_setup ^ out_ep_acked;

    assign out_ep_stall    = 1'b0;
    assign in_ep_stall     = 1'b0;

    assign uart_tx_ready   = !w_tx_full;
    assign w_tx_push       = uart_tx_strobe && !w_tx_full;
    assign uart_rx_valid   = !w_rx_empty;
    assign w_rx_pop        = uart_rx_ready && !w_rx_empty;

    // A whole packet always fits once requested, so no mid-packet stall
    assign out_ep_req      = out_ep_data_avail && (rx_level <= c_rx_req_max);
    assign out_ep_data_get = out_ep_grant;

    assign in_ep_req       = r_in_req;
    assign in_ep_data_put  = r_in_put;
    assign in_ep_data_done = r_in_done;
    assign in_ep_data      = r_in_data;

    usb_serial_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (w_tx_push),
        .wdata   (uart_tx_data),
        .pop     (w_tx_pop),
        .rdata   (w_tx_head),
        .rdata_q (w_unused_tx_head_q),
        .level   (tx_level),
        .empty   (w_tx_empty),
        .full    (w_tx_full)
    );

    usb_serial_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (r_out_wr),
        .wdata   (r_out_data),
        .pop     (w_rx_pop),
        .rdata   (w_unused_rx_head),
        .rdata_q (uart_rx_data),
        .level   (rx_level),
        .empty   (w_rx_empty),
        .full    (w_unused_rx_full)
    );

    // OUT pipeline: mark a get, capture its byte a cycle later, write next
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_get_d <= 1'b0;
            r_out_wr    <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_get_d <= out_ep_grant && out_ep_data_avail;
            r_out_wr    <= r_out_get_d;
            if (r_out_get_d) begin
                r_out_data <= out_ep_data;
            end
        end
    end

    assign w_flush_due = (r_timer == c_tmr_last);

    // Idle-flush timer: runs only while idle with data; any push restarts it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_tx_push || (r_state != ST_IDLE) || (w_state_nxt != ST_IDLE)) begin
            r_timer <= '0;
        end else if ((tx_level != '0) && !w_flush_due) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // IN packetiser next-state and pop decision
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tx_pop    = 1'b0;
        w_last      = 1'b0;
        w_put_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((tx_level >= c_tx_pkt) || ((tx_level != '0) && w_flush_due)) begin
                    w_state_nxt = ST_FILL;
                    w_cnt_nxt   = c_cnt_full;
                end
            end
            ST_FILL: begin
                if (in_ep_grant && in_ep_data_free && !w_tx_empty && (r_cnt != '0)) begin
                    w_tx_pop  = 1'b1;
                    w_put_nxt = 1'b1;
                    w_cnt_nxt = r_cnt - 1'b1;
                    // Packet ends on size, or when this pop drains the FIFO
                    w_last    = (r_cnt == c_cnt_one) || ((tx_level == c_tx_one) && !w_tx_push);
                    if (w_last) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_WAIT;
`ifdef USB_SERIAL_ZLP_EN
                        // Full-size packet that drained the FIFO needs a ZLP
                        if ((r_cnt == c_cnt_one) && (tx_level == c_tx_one) && !w_tx_push) begin
                            w_state_nxt = ST_ZLP;
                        end
`endif
                    end
                end
            end
`ifdef USB_SERIAL_ZLP_EN
            ST_ZLP: begin
                if (in_ep_grant && in_ep_data_free) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
`endif
            ST_WAIT: begin
                if (in_ep_acked) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // IN packetiser state and registered endpoint outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_in_req  <= 1'b0;
            r_in_put  <= 1'b0;
            r_in_done <= 1'b0;
            r_in_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_in_req  <= (w_state_nxt == ST_FILL) || (w_state_nxt == ST_ZLP);
            r_in_put  <= w_put_nxt;
            r_in_done <= w_done_nxt;
            if (w_tx_pop) begin
                r_in_data <= w_tx_head;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_usb_serial_pkt_ep.sv
// ============================================================================
// Module      : tb_usb_serial_pkt_ep
// Description : Directed self-checking bench for usb_serial_pkt_ep
//               (MAX_PKT=32, depths 64, FLUSH_CYCLES=16). Honours
//               USB_SERIAL_ZLP_EN for the zero-length-packet expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_serial_pkt_ep;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       out_ep_req, out_ep_grant, out_ep_data_avail, out_ep_setup;
    logic       out_ep_data_get, out_ep_stall, out_ep_acked;
    logic [7:0] out_ep_data;
    logic       in_ep_req, in_ep_grant, in_ep_data_free, in_ep_data_put;
    logic       in_ep_data_done, in_ep_stall, in_ep_acked;
    logic [7:0] in_ep_data;
    logic       uart_tx_ready, uart_tx_strobe, uart_rx_valid, uart_rx_ready;
    logic [7:0] uart_tx_data, uart_rx_data;
    logic [6:0] tx_level, rx_level;

    int n_checks = 0;
    int n_fail   = 0;

    // IN-side observation (filled by the monitor below)
    logic [7:0] put_q[$];
    int         done_at[$];
    int         done_total = 0;
    int         zlp_cnt = 0;

    usb_serial_pkt_ep #(
        .TX_DEPTH     (64),
        .RX_DEPTH     (64),
        .MAX_PKT      (32),
        .FLUSH_CYCLES (16)
    ) u_dut (
        .clk               (clk),
        .reset             (reset),
        .out_ep_req        (out_ep_req),
        .out_ep_grant      (out_ep_grant),
        .out_ep_data_avail (out_ep_data_avail),
        .out_ep_setup      (out_ep_setup),
        .out_ep_data_get   (out_ep_data_get),
        .out_ep_data       (out_ep_data),
        .out_ep_stall      (out_ep_stall),
        .out_ep_acked      (out_ep_acked),
        .in_ep_req         (in_ep_req),
        .in_ep_grant       (in_ep_grant),
        .in_ep_data_free   (in_ep_data_free),
        .in_ep_data_put    (in_ep_data_put),
        .in_ep_data        (in_ep_data),
        .in_ep_data_done   (in_ep_data_done),
        .in_ep_stall       (in_ep_stall),
        .in_ep_acked       (in_ep_acked),
        .uart_tx_ready     (uart_tx_ready),
        .uart_tx_data      (uart_tx_data),
        .uart_tx_strobe    (uart_tx_strobe),
        .uart_rx_data      (uart_rx_data),
        .uart_rx_valid     (uart_rx_valid),
        .uart_rx_ready     (uart_rx_ready),
        .tx_level          (tx_level),
        .rx_level          (rx_level)
    );

    always #5 clk = ~clk;

    // Record IN puts and packet terminations on the quiet edge
    always @(negedge clk) begin
        if (!reset) begin
            if (in_ep_data_put) put_q.push_back(in_ep_data);
            if (in_ep_data_done) begin
                done_total++;
                if (in_ep_data_put) done_at.push_back(put_q.size());
                else                zlp_cnt++;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            uart_tx_data   = first + 8'(i);
            uart_tx_strobe = 1'b1;
            step();
        end
        uart_tx_strobe = 1'b0;
    endtask

    // Host IN buffer: accept bytes until done, then stop taking data and ack
    task automatic run_in_packet(input string tag);
        int n = done_total;
        int t = 0;
        in_ep_data_free = 1'b1;
        while (done_total == n && t < 200) begin
            step();
            t++;
        end
        check_val({tag, "_done_timeout"}, 64'(t < 200), 64'd1);
        in_ep_data_free = 1'b0;
        step();
        in_ep_acked = 1'b1;
        step();
        in_ep_acked = 1'b0;
    endtask

`ifdef USB_SERIAL_ZLP_EN
    task automatic serve_zlp(input string tag);
        int n = zlp_cnt;
        int t = 0;
        in_ep_data_free = 1'b1;
        while (zlp_cnt == n && t < 50) begin
            step();
            t++;
        end
        check_val({tag, "_zlp_timeout"}, 64'(t < 50), 64'd1);
        in_ep_data_free = 1'b0;
        step();
        in_ep_acked = 1'b1;
        step();
        in_ep_acked = 1'b0;
    endtask
`endif

    // Host OUT buffer: wait for request, deliver n bytes one cycle after each get
    task automatic host_out_packet(input logic [7:0] first, input int n, input bit chk_lat);
        int t = 0;
        out_ep_data_avail = 1'b1;
        #1;
        while (!out_ep_req && t < 50) begin
            step();
            t++;
        end
        check_val("out_req_timeout", 64'(t < 50), 64'd1);
        out_ep_grant = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            out_ep_data = first + 8'(i);
            if (chk_lat && i == 1) check_val("rx_valid_g2", 64'(uart_rx_valid), 64'd0);
            if (chk_lat && i == 2) check_val("rx_valid_g3", 64'(uart_rx_valid), 64'd1);
            if (i == n - 1) begin
                out_ep_grant      = 1'b0;
                out_ep_data_avail = 1'b0;
            end
        end
        step();
    endtask

    task automatic pop_rx(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("rx_data%0d", i), 64'(uart_rx_data), 64'(first + 8'(i)));
            uart_rx_ready = 1'b1;
            step();
        end
        uart_rx_ready = 1'b0;
    endtask

    initial begin
        int z0;
        int t;
        int np;
        int nd;
        logic early;
        out_ep_grant = 0; out_ep_data_avail = 0; out_ep_setup = 0; out_ep_data = 0;
        out_ep_acked = 0; in_ep_grant = 0; in_ep_data_free = 0; in_ep_acked = 0;
        uart_tx_data = 0; uart_tx_strobe = 0; uart_rx_ready = 0;

        // Reset state
        step(); step();
        check_val("rst_outs", {in_ep_req, in_ep_data_put, in_ep_data_done, in_ep_data,
                               tx_level, rx_level, uart_rx_data, uart_rx_valid}, '0);
        reset = 1'b0;
        step();
        check_val("rst_ready", {uart_tx_ready, out_ep_req, out_ep_stall, in_ep_stall}, 64'b1000);
        in_ep_grant     = 1'b1;
        in_ep_data_free = 1'b1;

        // A: one full packet 0x00..0x1F
        put_q.delete(); done_at.delete(); z0 = zlp_cnt;
        push_seq(8'h00, 32);
        run_in_packet("a");
        check_val("a_nput", 64'(put_q.size()), 64'd32);
        for (int i = 0; i < put_q.size(); i++) check_val($sformatf("a_put%0d", i), 64'(put_q[i]), 64'(i));
        check_val("a_done_idx", 64'((done_at.size() == 1) ? done_at[0] : -1), 64'd32);
`ifdef USB_SERIAL_ZLP_EN
        serve_zlp("a");
        check_val("a_zlp", 64'(zlp_cnt - z0), 64'd1);
`else
        in_ep_data_free = 1'b1;
        repeat (5) step();
        check_val("a_zlp", 64'(zlp_cnt - z0), 64'd0);
`endif
        in_ep_data_free = 1'b1;

        // B: 5 bytes flushed by the idle timer, request 17 cycles after last push
        put_q.delete(); done_at.delete(); z0 = zlp_cnt;
        push_seq(8'h40, 5);
        early = in_ep_req;
        for (int k = 0; k < 15; k++) begin
            step();
            early = early | in_ep_req;
        end
        check_val("b_req_early", 64'(early), 64'd0);
        step();
        check_val("b_req_at17", 64'(in_ep_req), 64'd1);
        run_in_packet("b");
        check_val("b_nput", 64'(put_q.size()), 64'd5);
        for (int i = 0; i < put_q.size(); i++) check_val($sformatf("b_put%0d", i), 64'(put_q[i]), 64'(8'h40 + i));
        check_val("b_done_idx", 64'((done_at.size() == 1) ? done_at[0] : -1), 64'd5);
        in_ep_data_free = 1'b1;
        repeat (5) step();
        check_val("b_zlp", 64'(zlp_cnt - z0), 64'd0);

        // C/D: OUT packet 0xA0..0xBF, then 8 more to reach 40/64
        host_out_packet(8'hA0, 32, 1'b1);
        repeat (3) step();
        check_val("d_rx_level32", 64'(rx_level), 64'd32);
        host_out_packet(8'hC0, 8, 1'b0);
        repeat (3) step();
        check_val("c_rx_level40", 64'(rx_level), 64'd40);
        out_ep_data_avail = 1'b1;
        #1;
        check_val("c_req_held", 64'(out_ep_req), 64'd0);
        repeat (3) step();
        check_val("c_req_still", 64'(out_ep_req), 64'd0);
        pop_rx(8'hA0, 8);
        check_val("c_req_rise", 64'(out_ep_req), 64'd1);
        out_ep_data_avail = 1'b0;
        pop_rx(8'hA8, 32);
        check_val("d_rx_empty", {57'd0, rx_level}, 64'd0);
        check_val("d_rx_valid", 64'(uart_rx_valid), 64'd0);

        // E: fill TX to 64 with the host not taking data, overflow push, two packets
        put_q.delete(); done_at.delete(); z0 = zlp_cnt;
        in_ep_data_free = 1'b0;
        push_seq(8'h00, 64);
        check_val("e_level64", 64'(tx_level), 64'd64);
        check_val("e_ready0", 64'(uart_tx_ready), 64'd0);
        push_seq(8'hEE, 1);
        check_val("e_drop", 64'(tx_level), 64'd64);
        run_in_packet("e1");
        run_in_packet("e2");
        check_val("e_nput", 64'(put_q.size()), 64'd64);
        for (int i = 0; i < put_q.size(); i++) check_val($sformatf("e_put%0d", i), 64'(put_q[i]), 64'(i));
        check_val("e_done_n", 64'(done_at.size()), 64'd2);
        check_val("e_done_idx0", 64'((done_at.size() == 2) ? done_at[0] : -1), 64'd32);
        check_val("e_done_idx1", 64'((done_at.size() == 2) ? done_at[1] : -1), 64'd64);
`ifdef USB_SERIAL_ZLP_EN
        serve_zlp("e");
        check_val("e_zlp", 64'(zlp_cnt - z0), 64'd1);
`else
        in_ep_data_free = 1'b1;
        repeat (5) step();
        check_val("e_zlp", 64'(zlp_cnt - z0), 64'd0);
`endif
        check_val("e_tx_empty", 64'(tx_level), 64'd0);
        in_ep_data_free = 1'b1;

        // F: reset in the middle of a packet
        put_q.delete(); done_at.delete();
        nd = done_total;
        push_seq(8'h00, 32);
        t = 0;
        while (put_q.size() < 10 && t < 100) begin
            step();
            t++;
        end
        check_val("f_put_timeout", 64'(t < 100), 64'd1);
        reset = 1'b1;
        #1;
        np = put_q.size();
        check_val("f_rst_outs", {in_ep_req, in_ep_data_put, in_ep_data_done, in_ep_data,
                                 tx_level, rx_level, uart_rx_data}, '0);
        step(); step();
        reset = 1'b0;
        repeat (25) step();
        check_val("f_levels", {tx_level, rx_level}, '0);
        check_val("f_req", 64'(in_ep_req), 64'd0);
        check_val("f_no_put", 64'(put_q.size()), 64'(np));
        check_val("f_no_done", 64'(done_total), 64'(nd));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
